// File: rtl/mux_pkg.sv
// Shared defaults and the select-width helper for the registered N-way mux.
package mux_pkg;

  localparam int MUX_W_DEF = 32;
  localparam int MUX_N_DEF = 16;

  // Width of a channel index for an n-channel mux; never narrower than 1 bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_ptr.sv
// Wrapping SW-bit round-robin pointer with enable and synchronous active-low reset.
module mux_rr_ptr #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [SW-1:0] ptr
);

  // N is a power of two, so natural SW-bit overflow gives the N-1 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (!rst_n)  ptr <= '0;
    else if (en) ptr <= ptr + SW'(1);
  end

endmodule

// File: rtl/mux_n_reg.sv
// N-way W-bit mux with a one-slot registered output and valid/ready handshakes.
// Define MUX_N_REG_RR_EN to add the rr_mode port and round-robin channel scan.
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int W  = MUX_W_DEF,
  parameter int N  = MUX_N_DEF,
  parameter int SW = sel_w(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_flat,
  input  logic [SW-1:0]  sel,
  input  logic           req_valid,
  output logic           req_ready,
`ifdef MUX_N_REG_RR_EN
  input  logic           rr_mode,
`endif
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [N-1:0][W-1:0] chans;
  logic [SW-1:0]       ch;
  logic                accept;

  assign chans     = in_flat;
  assign req_ready = ~out_valid | out_ready;
  assign accept    = req_valid & req_ready;

`ifdef MUX_N_REG_RR_EN
  logic [SW-1:0] rr_ptr;

  mux_rr_ptr #(.SW(SW)) u_rr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept & rr_mode),
    .ptr   (rr_ptr)
  );

  assign ch = rr_mode ? rr_ptr : sel;
`else
  assign ch = sel;
`endif

  // Accept wins over drain, so a simultaneous accept+drain reloads with valid held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= chans[ch];
      out_sel   <= ch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench for mux_n_reg: driver pushes expected results, negedge monitor compares.
module tb_mux_n_reg;
  localparam int W  = 32;
  localparam int N  = 16;
  localparam int SW = 4;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_flat = '0;
  logic [SW-1:0]  sel = '0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
`ifdef MUX_N_REG_RR_EN
  logic           rr_mode = 1'b0;
`endif

  exp_t          q[$];
  int            errs = 0;
  int            checks = 0;
  bit            mon_en = 1'b0;
  bit            started = 1'b0;
  bit            m_valid = 1'b0;
  logic [SW-1:0] m_rr = '0;

  always #5 clk = ~clk;

  mux_n_reg #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flat   (in_flat),
    .sel       (sel),
    .req_valid (req_valid),
    .req_ready (req_ready),
`ifdef MUX_N_REG_RR_EN
    .rr_mode   (rr_mode),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, advance the reference model at the edge.
  task automatic step(input bit rv, input int s, input bit ordy, input bit rrm = 1'b0,
                      input bit rst = 1'b1);
    logic [SW-1:0] ch;
    bit            acc;
    rst_n     = rst;
    req_valid = rv;
    sel       = SW'(s);
    out_ready = ordy;
`ifdef MUX_N_REG_RR_EN
    rr_mode   = rrm;
`endif
    #1;
    if (started) chk("req_ready", 64'(req_ready), 64'(!m_valid || ordy));
    @(posedge clk);
    started = 1'b1;
    if (!rst) begin
      q.delete();
      m_valid = 1'b0;
      m_rr    = '0;
    end else begin
      acc = rv && (!m_valid || ordy);
      ch  = (rrm != 1'b0) ? m_rr : SW'(s);
`ifndef MUX_N_REG_RR_EN
      ch  = SW'(s);
`endif
      if (acc) begin
        q.push_back('{in_flat[ch*W +: W], ch});
        m_valid = 1'b1;
        if (rrm) m_rr = m_rr + SW'(1);
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_sel", 64'(out_sel), 64'(q[0].s));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) in_flat[k*W +: W] = 32'hA000_0000 + 32'(k);

    // reset held two cycles with a live request
    step(1, 5, 1, 0, 0);
    step(1, 5, 1, 0, 0);
    mon_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // direct select
    step(1, 5, 1);
    chk("direct_data", 64'(out_data), 64'hA000_0005);
    chk("direct_sel", 64'(out_sel), 64'd5);
    step(0, 0, 1);

    // backpressure: channel 3 held while 9 waits
    step(1, 3, 0);
    step(1, 9, 0);
    chk("bp_hold_data", 64'(out_data), 64'hA000_0003);
    step(1, 9, 0);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    step(1, 9, 1);
    chk("bp_next_data", 64'(out_data), 64'hA000_0009);
    step(0, 0, 1);

    // no request: input changes must not reach the outputs
    in_flat[7*W +: W] = 32'hDEAD_BEEF;
    step(0, 7, 1);
    step(0, 2, 0);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // streaming with a different data pattern
    for (int k = 0; k < N; k++) in_flat[k*W +: W] = 32'h5A00_0000 + 32'(k * 257);
    for (int i = 0; i < 4; i++) begin
      step(1, i, 1);
      chk("stream_sel", 64'(out_sel), 64'(i));
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    chk("stream_data3", 64'(out_data), 64'h5A00_0303);
    step(0, 0, 1);

    // held result survives input churn
    step(1, 2, 0);
    in_flat[2*W +: W] = 32'h1234_5678;
    step(0, 4, 0);
    chk("hold_data", 64'(out_data), 64'h5A00_0202);
    step(0, 0, 1);

`ifdef MUX_N_REG_RR_EN
    for (int i = 0; i < 17; i++) begin
      step(1, 7, 1, 1);
      chk("rr_sel", 64'(out_sel), 64'(i % 16));
    end
    step(1, 5, 1, 0);
    chk("rr_direct_sel", 64'(out_sel), 64'd5);
    step(1, 5, 1, 1);
    chk("rr_resume_sel", 64'(out_sel), 64'd1);
    step(0, 0, 1);
`endif

    // reset while a result is held under backpressure
    step(1, 6, 0, 1);
    step(0, 0, 0, 1, 0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    step(1, 6, 1, 1);
`ifdef MUX_N_REG_RR_EN
    chk("midrst_sel", 64'(out_sel), 64'd0);
`else
    chk("midrst_sel", 64'(out_sel), 64'd6);
`endif
    step(0, 0, 1);
    step(0, 0, 1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
